temp_control: RTL and testbench
===============================

# temp_control

Thermostat controller for the smart-home automation design. It compares an 8-bit room temperature reading against a heating threshold and a cooling threshold, with hysteresis, and drives mutually exclusive Heat and Cool actuator enables. Outputs are registered and come straight from a three-state FSM clocked on CLK.

## Interface
- Reset scheme (already decided): one clock; reset is synchronous and active-high.
- HEAT_LOW, default 65: heating turns on when Temp < HEAT_LOW.
- COOL_HIGH, default 85: cooling turns on when Temp > COOL_HIGH.
- HYST, default 2: hysteresis band in degrees applied on exit from HEATING or COOLING.
- Parameter rule: HEAT_LOW + HYST <= COOL_HIGH − HYST. Violation is a configuration error, flagged by an elaboration-time check.
- CLK  input  1  rising-edge system clock.
- Reset  input  1  synchronous, active-high reset.
- Temp  input  8  unsigned temperature, whole degrees (0–255).
- Heat  output  1  heater enable, registered.
- Cool  output  1  cooler enable, registered.
- Positional port order is fixed: Heat, Cool, CLK, Temp, Reset.

## Operation
- FSM states: IDLE, HEATING, COOLING.
- Output decode: IDLE gives Heat=0, Cool=0. HEATING gives Heat=1, Cool=0. COOLING gives Heat=0, Cool=1.
- Heat and Cool are never both 1 in any cycle.
- Transitions are evaluated on each rising CLK edge when Reset=0.
- IDLE:
  - Temp < HEAT_LOW → HEATING.
  - Temp > COOL_HIGH → COOLING.
  - Otherwise stay in IDLE.
- HEATING:
  - Temp > COOL_HIGH → COOLING (direct, no IDLE cycle).
  - Otherwise Temp >= HEAT_LOW + HYST → IDLE.
  - Otherwise stay in HEATING.
- COOLING:
  - Temp < HEAT_LOW → HEATING (direct).
  - Otherwise Temp <= COOL_HIGH − HYST → IDLE.
  - Otherwise stay in COOLING.
- Arithmetic:
  - All comparisons are unsigned.
  - HEAT_LOW + HYST is computed at 9 bits, so no wrap near 255.
  - COOL_HIGH − HYST saturates at 0, so no underflow.
- Boundary values with default parameters:
  - Temp=65 from IDLE does not heat.
  - Temp=85 from IDLE does not cool.
  - Temp=64 heats; Temp=86 cools.
  - HEATING holds for 65–66 and releases at 67.
  - COOLING holds for 84–85 and releases at 83.
- Reset:
  - Reset=1 at a rising edge forces IDLE, so Heat=0 and Cool=0, regardless of Temp or current state.
  - Reset has priority over all transitions, including mid-HEATING or mid-COOLING.
- Unknown Temp: an X/Z Temp is not defined behaviour. A simulation-only assertion flags it when Reset=0.

## Timing
- Latency: a Temp change sampled at rising edge N appears on Heat/Cool after edge N, and is stable before edge N+1. That is one cycle of latency.
- No combinational path from Temp or Reset to the outputs.
- Reset is synchronous: asserting Reset between edges has no effect until the next rising edge.
- After Reset deasserts, the first edge with Reset=0 evaluates Temp from IDLE.
- Temp may change every cycle, and each edge makes at most one state transition.
- No handshake: the block is free-running and has no enable.

## Test plan
- Reset for one edge with Temp unknown or any value → Heat=0, Cool=0 at that edge. Release Reset and hold Temp=70 → Heat=0, Cool=0.
- IDLE, Temp=93 → Cool=1, Heat=0 one edge later. Then Temp=60 → HEATING directly: Heat=1, Cool=0 one edge later.
- Threshold edges from IDLE, one at a time:
  - Temp=65 → no heat; Temp=64 → Heat=1.
  - Reset, then Temp=85 → no cool; Temp=86 → Cool=1.
- Hysteresis in HEATING at Temp=60, then step Temp 65, 66, 67 → Heat stays 1 at 65 and 66, drops to 0 one edge after 67.
- Hysteresis in COOLING at Temp=90, then step Temp 85, 84, 83 → Cool stays 1 through 84, drops one edge after 83.
- Reset mid-operation:
  - In COOLING with Temp=100, pulse Reset for one edge → outputs 0 at that edge, Cool=1 again the edge after release.
  - Sweep Temp 0→255→0 over all values and check Heat&Cool==0 every cycle.

Source files
------------

// File: rtl/temp_control.sv
// temp_control: hysteretic thermostat FSM with mutually exclusive, registered Heat/Cool enables.
module temp_control #(
    parameter int HEAT_LOW  = 65,
    parameter int COOL_HIGH = 85,
    parameter int HYST      = 2
) (
    output logic       Heat,
    output logic       Cool,
    input  logic       CLK,
    input  logic [7:0] Temp,
    input  logic       Reset
);
    if (HEAT_LOW + HYST > COOL_HIGH - HYST) begin : g_bad_params
        $error("temp_control: HEAT_LOW + HYST must not exceed COOL_HIGH - HYST");
    end

    // State bits double as the actuator enables, so outputs come straight from flops.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HEATING = 2'b01,
        COOLING = 2'b10
    } state_t;

    localparam logic [8:0] HEAT_ON  = 9'(HEAT_LOW);
    localparam logic [8:0] COOL_ON  = 9'(COOL_HIGH);
    localparam logic [8:0] HEAT_OFF = 9'(HEAT_LOW) + 9'(HYST);
    localparam logic [8:0] COOL_OFF = (COOL_HIGH > HYST) ? 9'(COOL_HIGH - HYST) : 9'd0;

    state_t     r_state;
    state_t     w_next;
    logic [8:0] w_temp;
    logic       w_cold;
    logic       w_hot;

    assign w_temp = {1'b0, Temp};
    assign w_cold = w_temp < HEAT_ON;
    assign w_hot  = w_temp > COOL_ON;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_cold ? HEATING : w_hot ? COOLING : IDLE;
            HEATING: w_next = w_hot ? COOLING : (w_temp >= HEAT_OFF) ? IDLE : HEATING;
            COOLING: w_next = w_cold ? HEATING : (w_temp <= COOL_OFF) ? IDLE : COOLING;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    assign Heat = r_state[0];
    assign Cool = r_state[1];

    always_ff @(posedge CLK) begin
        if (!Reset)
            assert (!$isunknown(Temp)) else $error("temp_control: Temp is X/Z while out of reset");
    end
endmodule

// File: tb/tb_temp_control.sv
// tb_temp_control: directed thermostat stimulus checked every cycle against a threshold model.
module tb_temp_control;
    localparam int HL = 65;
    localparam int CH = 85;
    localparam int HY = 2;

    logic       CLK   = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] Temp  = 'x;
    logic       Heat;
    logic       Cool;

    int n_cmp  = 0;
    int n_bad  = 0;
    int m_mode = 0;
    int m_t;
    bit run    = 1'b0;

    temp_control #(.HEAT_LOW(HL), .COOL_HIGH(CH), .HYST(HY)) dut (
        .Heat(Heat), .Cool(Cool), .CLK(CLK), .Temp(Temp), .Reset(Reset)
    );

    always #5 CLK = ~CLK;

    // Model: 0 = off, 1 = heating, 2 = cooling; extremes win, hysteresis only governs release.
    always @(posedge CLK) begin
        if (Reset) m_mode = 0;
        else begin
            m_t = int'(Temp);
            if (m_t > CH) m_mode = 2;
            else if (m_t < HL) m_mode = 1;
            else if (m_mode == 1 && m_t >= HL + HY) m_mode = 0;
            else if (m_mode == 2 && m_t <= ((CH > HY) ? CH - HY : 0)) m_mode = 0;
        end
    end

    always @(negedge CLK) begin
        if (run) begin
            n_cmp++;
            if (Heat !== (m_mode == 1) || Cool !== (m_mode == 2)) begin
                n_bad++;
                $display("FAIL model: Heat=%b Cool=%b expected Heat=%b Cool=%b (Temp=%0d)",
                         Heat, Cool, m_mode == 1, m_mode == 2, Temp);
            end
            n_cmp++;
            if (Heat !== 1'b0 && Cool !== 1'b0) begin
                n_bad++;
                $display("FAIL exclusive: Heat=%b Cool=%b expected not both 1", Heat, Cool);
            end
        end
    end

    task automatic step(input logic [7:0] t, input logic r);
        @(negedge CLK);
        Temp  = t;
        Reset = r;
        @(posedge CLK);
        #1;
    endtask

    task automatic lit(input string nm, input logic eh, input logic ec);
        n_cmp++;
        if (Heat !== eh || Cool !== ec) begin
            n_bad++;
            $display("FAIL %s: Heat=%b Cool=%b expected Heat=%b Cool=%b", nm, Heat, Cool, eh, ec);
        end
        n_cmp++;
        if ((m_mode == 1) != eh || (m_mode == 2) != ec) begin
            n_bad++;
            $display("FAIL %s model pin: mode=%0d expected Heat=%b Cool=%b", nm, m_mode, eh, ec);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        step('x, 1'b1);  run = 1'b1; lit("reset_x", 0, 0);
        step(70, 1'b0);  lit("idle70", 0, 0);
        step(93, 1'b0);  lit("cool93", 0, 1);
        step(60, 1'b0);  lit("cool_to_heat60", 1, 0);
        step(70, 1'b1);  lit("reset_heat", 0, 0);
        step(65, 1'b0);  lit("idle65_no_heat", 0, 0);
        step(64, 1'b0);  lit("idle64_heat", 1, 0);
        step(70, 1'b1);  lit("reset2", 0, 0);
        step(85, 1'b0);  lit("idle85_no_cool", 0, 0);
        step(86, 1'b0);  lit("idle86_cool", 0, 1);
        step(60, 1'b0);  lit("heat60", 1, 0);
        step(65, 1'b0);  lit("heat_hold65", 1, 0);
        step(66, 1'b0);  lit("heat_hold66", 1, 0);
        step(67, 1'b0);  lit("heat_release67", 0, 0);
        step(90, 1'b0);  lit("cool90", 0, 1);
        step(85, 1'b0);  lit("cool_hold85", 0, 1);
        step(84, 1'b0);  lit("cool_hold84", 0, 1);
        step(83, 1'b0);  lit("cool_release83", 0, 0);
        step(100, 1'b0); lit("cool100", 0, 1);
        step(100, 1'b1); lit("reset_mid_cool", 0, 0);
        step(100, 1'b0); lit("cool_after_reset", 0, 1);
        step(50, 1'b0);  lit("heat50_direct", 1, 0);
        step(50, 1'b1);  lit("reset_mid_heat", 0, 0);
        step(50, 1'b0);  lit("heat_after_reset", 1, 0);
        @(negedge CLK);
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        lit("reset_between_edges", 1, 0);
        step(70, 1'b1);
        for (int i = 0; i < 256; i++) step(8'(i), 1'b0);
        lit("sweep_top", 0, 1);
        for (int i = 255; i >= 0; i--) step(8'(i), 1'b0);
        lit("sweep_bottom", 1, 0);
        @(negedge CLK);
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
